i2c_slave_regs: RTL

- I2C target (slave) that is the bus-side counterpart of i2c_master_top. It serves a small register file to an external I2C master.
- SCL and SDA are oversampled on wb_clk_i. SDA is driven only through the open-drain pad pair (sda_pad_o / sda_padoen_o).
- A local parallel port lets the core logic read and write the same registers. Standard-mode and fast-mode framing only; no clock stretching and no 10-bit addressing.

---
 rtl/i2c_slave_regs.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target serving a small register file to an external master, with a local parallel port.
// SCL/SDA are synchronized and glitch-filtered; SDA is driven only through the open-drain pad pair.
module i2c_slave_regs #(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned ADR_W    = 3,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             wb_clk_i,
  input  logic             rst_i,
  input  logic             scl_pad_i,
  input  logic             sda_pad_i,
  output logic             sda_pad_o,
  output logic             sda_padoen_o,
  input  logic [ADR_W-1:0] reg_adr_i,
  input  logic [7:0]       reg_dat_i,
  input  logic             reg_we_i,
  output logic [7:0]       reg_dat_o,
  output logic             wr_strobe_o,
  output logic [ADR_W-1:0] wr_adr_o,
  output logic             busy_o
);

  localparam int unsigned NREGS = 2 ** ADR_W;

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRdataAck = 4'd8;
  localparam logic [3:0] StWait     = 4'd9;

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                scl_fp_q, sda_fp_q;

  logic [3:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic             full_q, full_d;
  logic             rw_q, rw_d;
  logic [ADR_W-1:0] ptr_q, ptr_d;
  logic             oen_q, oen_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic [ADR_W-1:0] wr_adr_q, wr_adr_d;
  logic [7:0]       regs_q [NREGS];
  logic [7:0]       regs_d [NREGS];

  logic scl_rise, scl_fall, start_det, stop_det;

  // A filtered level only moves once FILT_LEN consecutive samples agree.
  always_comb begin
    scl_f_d = scl_f_q;
    sda_f_d = sda_f_q;
    if (&scl_hist_q)       scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    if (&sda_hist_q)       sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_fp_q   <= 1'b1;
      sda_fp_q   <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_pad_i};
      sda_sync_q <= {sda_sync_q[0], sda_pad_i};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_fp_q   <= scl_f_q;
      sda_fp_q   <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_fp_q;
  assign scl_fall  = ~scl_f_q & scl_fp_q;
  assign start_det = scl_f_q & scl_fp_q & sda_fp_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_fp_q & ~sda_fp_q & sda_f_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    full_d   = full_q;
    rw_d     = rw_q;
    ptr_d    = ptr_q;
    oen_d    = oen_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    wr_adr_d = wr_adr_q;
    regs_d   = regs_q;

    if (stop_det) begin
      state_d = StIdle;
      cnt_d   = '0;
      full_d  = 1'b0;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      sr_d    = '0;
      full_d  = 1'b0;
      oen_d   = 1'b1;
    end else if (scl_rise) begin
      unique case (state_q)
        StAddr, StPtr, StWdata: begin
          sr_d   = {sr_q[6:0], sda_f_q};
          cnt_d  = cnt_q + 3'd1;
          full_d = (cnt_q == 3'd7);
        end
        StRdata: begin
          cnt_d  = cnt_q + 3'd1;
          full_d = (cnt_q == 3'd7);
        end
        StRdataAck: begin
          rw_d = sda_f_q;  // reused as the master's NACK bit during the read ACK slot
          if (!sda_f_q) ptr_d = ptr_q + ADR_W'(1);
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      unique case (state_q)
        StAddr: if (full_q) begin
          full_d = 1'b0;
          if (sr_q[7:1] == SLV_ADDR) begin
            state_d = StAddrAck;
            oen_d   = 1'b0;
            busy_d  = 1'b1;
            rw_d    = sr_q[0];
          end else begin
            state_d = StWait;
            busy_d  = 1'b0;
          end
        end
        StAddrAck: begin
          if (rw_q) begin
            state_d = StRdata;
            sr_d    = regs_q[ptr_q];
            oen_d   = regs_q[ptr_q][7];
          end else begin
            state_d = StPtr;
            oen_d   = 1'b1;
          end
        end
        StPtr: if (full_q) begin
          full_d  = 1'b0;
          ptr_d   = sr_q[ADR_W-1:0];
          state_d = StPtrAck;
          oen_d   = 1'b0;
        end
        StPtrAck, StWdataAck: begin
          state_d = StWdata;
          oen_d   = 1'b1;
        end
        StWdata: if (full_q) begin
          full_d        = 1'b0;
          regs_d[ptr_q] = sr_q;
          strobe_d      = 1'b1;
          wr_adr_d      = ptr_q;
          ptr_d         = ptr_q + ADR_W'(1);
          state_d       = StWdataAck;
          oen_d         = 1'b0;
        end
        StRdata: begin
          if (full_q) begin
            full_d  = 1'b0;
            oen_d   = 1'b1;
            state_d = StRdataAck;
          end else begin
            sr_d  = {sr_q[6:0], 1'b0};
            oen_d = sr_q[6];
          end
        end
        StRdataAck: begin
          if (rw_q) begin
            state_d = StWait;
            busy_d  = 1'b0;
            oen_d   = 1'b1;
          end else begin
            state_d = StRdata;
            sr_d    = regs_q[ptr_q];
            oen_d   = regs_q[ptr_q][7];
          end
        end
        default: ;
      endcase
    end

    // Local port has the last word on a same-cycle write collision.
    if (reg_we_i) regs_d[reg_adr_i] = reg_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sr_q     <= '0;
      full_q   <= 1'b0;
      rw_q     <= 1'b0;
      ptr_q    <= '0;
      oen_q    <= 1'b1;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      wr_adr_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      full_q   <= full_d;
      rw_q     <= rw_d;
      ptr_q    <= ptr_d;
      oen_q    <= oen_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      wr_adr_q <= wr_adr_d;
      regs_q   <= regs_d;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign busy_o       = busy_q;
  assign wr_strobe_o  = strobe_q;
  assign wr_adr_o     = wr_adr_q;
  assign reg_dat_o    = regs_q[reg_adr_i];

endmodule
